// File: rtl/upmult_pkg.sv
// rtl/upmult_pkg.sv - micro-word layout, sequencing encodings and micro-addresses for upmult_seq
package upmult_pkg;

  // Register-control field positions within a micro-word
  localparam int UW_LD_M   = 0;
  localparam int UW_LD_Q   = 1;
  localparam int UW_CLR_R  = 2;
  localparam int UW_ADD_R  = 3;
  localparam int UW_DEC_Q  = 4;
  localparam int UW_DONE   = 5;
  localparam int UW_CS_LSB = 6;
  localparam int UW_CC     = 8;
  localparam int UW_AD_LSB = 9;
  localparam int UW_WIDTH  = 12;

  typedef enum logic [1:0] {
    CS_INC = 2'd0,
    CS_BZ  = 2'd1,
    CS_JMP = 2'd2
  } csel_t;

  typedef enum logic {
    CC_NOT_START = 1'b0,
    CC_QZERO     = 1'b1
  } cond_t;

  localparam logic [2:0] A_IDLE = 3'd0;
  localparam logic [2:0] A_TEST = 3'd1;
  localparam logic [2:0] A_ADD  = 3'd2;
  localparam logic [2:0] A_DEC  = 3'd3;
  localparam logic [2:0] A_DONE = 3'd4;

  function automatic logic [UW_WIDTH-1:0] mk_uword(input logic [5:0] ctl, input csel_t cs,
                                                   input cond_t cc, input logic [2:0] addr);
    return {addr, cc, cs, ctl};
  endfunction

endpackage

// File: rtl/upmult_urom.sv
// rtl/upmult_urom.sv - combinational 5-word micro-ROM for the successive-addition multiplier
module upmult_urom
  import upmult_pkg::*;
(
  input  logic [2:0]          upc,
  output logic [UW_WIDTH-1:0] uword
);

  localparam logic [5:0] C_NONE  = 6'd0;
  localparam logic [5:0] C_LOAD  = 6'((1 << UW_LD_M) | (1 << UW_LD_Q) | (1 << UW_CLR_R));
  localparam logic [5:0] C_ADD   = 6'(1 << UW_ADD_R);
  localparam logic [5:0] C_DEC   = 6'(1 << UW_DEC_Q);
  localparam logic [5:0] C_DONE  = 6'(1 << UW_DONE);

  always_comb begin
    uword = mk_uword(C_NONE, CS_JMP, CC_NOT_START, A_IDLE);
    case (upc)
      A_IDLE:  uword = mk_uword(C_LOAD, CS_BZ,  CC_NOT_START, A_IDLE);
      A_TEST:  uword = mk_uword(C_NONE, CS_BZ,  CC_QZERO,     A_DONE);
      A_ADD:   uword = mk_uword(C_ADD,  CS_INC, CC_NOT_START, A_IDLE);
      A_DEC:   uword = mk_uword(C_DEC,  CS_JMP, CC_NOT_START, A_TEST);
      A_DONE:  uword = mk_uword(C_DONE, CS_JMP, CC_NOT_START, A_IDLE);
      default: uword = mk_uword(C_NONE, CS_JMP, CC_NOT_START, A_IDLE);
    endcase
  end

endmodule

// File: rtl/upmult_seq.sv
// rtl/upmult_seq.sv - microprogrammed M x Q multiplier; UPMULT_ACC_EN adds accumulate and sticky overflow
module upmult_seq
  import upmult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   m_in,
  input  logic [WIDTH-1:0]   q_in,
`ifdef UPMULT_ACC_EN
  input  logic               acc,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
`ifdef UPMULT_ACC_EN
  output logic               overflow,
`endif
  output logic [2:0]         upc
);

  localparam int PW = 2 * WIDTH;

  logic [2:0]          upc_q;
  logic [2:0]          upc_nxt;
  logic [UW_WIDTH-1:0] uword;
  csel_t               csel;
  logic                cond;
  logic                ld_m, ld_q, clr_r, add_r, dec_q, clr_eff;
  logic [WIDTH-1:0]    m_reg, q_reg;
  logic [PW-1:0]       r_reg;

  upmult_urom u_urom (
    .upc   (upc_q),
    .uword (uword)
  );

  assign csel = csel_t'(uword[UW_CS_LSB +: 2]);
  assign cond = (cond_t'(uword[UW_CC]) == CC_QZERO) ? (q_reg == '0) : !start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) upc_q <= A_IDLE;
    else       upc_q <= upc_nxt;
  end

  always_comb begin
    upc_nxt = upc_q + 3'd1;
    case (csel)
      CS_INC:  upc_nxt = upc_q + 3'd1;
      CS_BZ:   upc_nxt = cond ? uword[UW_AD_LSB +: 3] : upc_q + 3'd1;
      CS_JMP:  upc_nxt = uword[UW_AD_LSB +: 3];
      default: upc_nxt = A_IDLE;
    endcase
  end

  // A taken BZ suppresses the word's register controls, so IDLE only loads on start
  always_comb begin
    logic en;
    en    = !((csel == CS_BZ) && cond);
    ld_m  = uword[UW_LD_M]  & en;
    ld_q  = uword[UW_LD_Q]  & en;
    clr_r = uword[UW_CLR_R] & en;
    add_r = uword[UW_ADD_R] & en;
    dec_q = uword[UW_DEC_Q] & en;
    done  = uword[UW_DONE];
    busy  = (upc_q != A_IDLE);
  end

`ifdef UPMULT_ACC_EN
  logic [PW:0] sum;
  logic        ovf_reg;
  assign clr_eff = clr_r & ~acc;
  assign sum     = {1'b0, r_reg} + {{(WIDTH + 1){1'b0}}, m_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ovf_reg <= 1'b0;
    else if (clr_eff)           ovf_reg <= 1'b0;
    else if (add_r && sum[PW])  ovf_reg <= 1'b1;
  end
  assign overflow = ovf_reg;
`else
  logic [PW-1:0] sum;
  assign clr_eff = clr_r;
  assign sum     = r_reg + {{WIDTH{1'b0}}, m_reg};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg <= '0;
      q_reg <= '0;
      r_reg <= '0;
    end else begin
      if (ld_m) m_reg <= m_in;
      if (ld_q)       q_reg <= q_in;
      else if (dec_q) q_reg <= q_reg - 1'b1;
      if (clr_eff)    r_reg <= '0;
      else if (add_r) r_reg <= sum[PW-1:0];
    end
  end

  assign product = r_reg;
  assign upc     = upc_q;

endmodule
